div_seq: RTL and testbench



---
 rtl/div_seq.sv | 118 +++++++++++
 tb/tb_div_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per cycle, signed or unsigned.
// Ports: clock, reset (sync, active-high), start, is_signed, A, B in; HI, LO, busy, done, div_0 out.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_0
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] bmag;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] amag_in;
  logic [WIDTH-1:0] bmag_in;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;

  // Magnitudes are unsigned WIDTH-bit, so |MIN_INT| is exact.
  always_comb begin
    a_neg   = is_signed & A[WIDTH-1];
    b_neg   = is_signed & B[WIDTH-1];
    amag_in = a_neg ? -A : A;
    bmag_in = b_neg ? -B : B;
  end

  // Shifted remainder needs WIDTH+1 bits; the restored value
  // always fits back into WIDTH bits since it is below |B|.
  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    ge      = shifted >= {1'b0, bmag};
    rem_nx  = ge ? WIDTH'(shifted - {1'b0, bmag})
                 : shifted[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    unique case (state)
      IDLE: if (start) state_nx = (B == '0) ? DONE : RUN;
      RUN:  if (cnt == CW'(1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem   <= '0;
      dvd   <= '0;
      bmag  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      div_0 <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            div_0 <= (B == '0);
            rem   <= '0;
            dvd   <= amag_in;
            bmag  <= bmag_in;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            cnt   <= CW'(WIDTH);
          end
        end
        RUN: begin
          rem <= rem_nx;
          dvd <= {dvd[WIDTH-2:0], ge};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          LO <= neg_q ? -dvd : dvd;
          HI <= neg_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: table-driven 32-bit vectors plus hand-written
// sequences for reset mid-run, held start, and an 8-bit instance.
module tb_div_seq;

  logic clk = 1'b0;
  logic reset;

  logic        start32, sgn32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        busy32, done32, dz32;

  logic        start8, sgn8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, dz8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32)) d32 (
    .clock(clk), .reset(reset), .start(start32), .is_signed(sgn32),
    .A(a32), .B(b32), .HI(hi32), .LO(lo32),
    .busy(busy32), .done(done32), .div_0(dz32)
  );

  div_seq #(.WIDTH(8)) d8 (
    .clock(clk), .reset(reset), .start(start8), .is_signed(sgn8),
    .A(a8), .B(b8), .HI(hi8), .LO(lo8),
    .busy(busy8), .done(done8), .div_0(dz8)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Entered at the first negedge after the accepting edge.
  task automatic wait32(output int lat, output int bc);
    lat = 1;
    bc  = 0;
    while (!done32 && lat < 60) begin
      if (busy32) bc++;
      @(negedge clk);
      lat++;
    end
    if (busy32) bc++;
  endtask

  task automatic wait8(output int lat, output int bc);
    lat = 1;
    bc  = 0;
    while (!done8 && lat < 60) begin
      if (busy8) bc++;
      @(negedge clk);
      lat++;
    end
    if (busy8) bc++;
  endtask

  task automatic op32(input logic s, input logic [31:0] a,
                      input logic [31:0] b,
                      output int lat, output int bc);
    @(negedge clk);
    sgn32 = s; a32 = a; b32 = b; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    wait32(lat, bc);
  endtask

  task automatic op8(input logic s, input logic [7:0] a,
                     input logic [7:0] b, output int lat);
    int bc;
    @(negedge clk);
    sgn8 = s; a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8(lat, bc);
  endtask

  initial begin
    int lat, bc;

    vecs[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
    vecs[2] = '{1'b1, 32'd7, 32'hFFFFFFFE,
                32'hFFFFFFFD, 32'd1, 1'b0, 34};
    vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
                32'h80000000, 32'd0, 1'b0, 34};
    vecs[4] = '{1'b0, 32'h80000000, 32'hFFFFFFFF,
                32'd0, 32'h80000000, 1'b0, 34};
    vecs[5] = '{1'b1, 32'hFFFFFF9C, 32'd7,
                32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34};
    vecs[6] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
                32'd14, 32'hFFFFFFFE, 1'b0, 34};
    vecs[7] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34};
    vecs[8] = '{1'b0, 32'd5, 32'd0, 32'd14, 32'd2, 1'b1, 1};
    vecs[9] = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34};

    reset = 1'b1;
    start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("rst outs32", {hi32, lo32}, 64'd0);
    chk("rst flags32", {61'd0, busy32, done32, dz32}, 64'd0);
    chk("rst outs8", {48'd0, hi8, lo8}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      op32(vecs[i].s, vecs[i].a, vecs[i].b, lat, bc);
      chk($sformatf("v%0d lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d busy", i), 64'(bc), 64'(vecs[i].lat));
      chk($sformatf("v%0d lo", i), 64'(lo32), 64'(vecs[i].lo));
      chk($sformatf("v%0d hi", i), 64'(hi32), 64'(vecs[i].hi));
      chk($sformatf("v%0d dz", i), 64'(dz32), 64'(vecs[i].dz));
      @(negedge clk);
      chk($sformatf("v%0d donepulse", i), 64'(done32), 64'd0);
    end

    // Reset mid-run discards the op; a start right after is accepted.
    @(negedge clk);
    sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst outs", {hi32, lo32}, 64'd0);
    chk("midrst flags", {61'd0, busy32, done32, dz32}, 64'd0);
    @(negedge clk);
    chk("midrst nodone", {62'd0, busy32, done32}, 64'd0);
    a32 = 32'd1000; b32 = 32'd10; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    a32 = 32'hDEADBEEF; b32 = 32'd3;
    wait32(lat, bc);
    chk("restart lat", 64'(lat), 64'd34);
    chk("restart lo", 64'(lo32), 64'd100);
    chk("restart hi", 64'(hi32), 64'd0);

    // Start coinciding with reset is lost.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; start32 = 1'b1;
    @(negedge clk);
    reset = 1'b0; start32 = 1'b0;
    @(negedge clk);
    chk("rst+start busy", 64'(busy32), 64'd0);

    // 8-bit instance, start held high across done.
    @(negedge clk);
    sgn8 = 1'b0; a8 = 8'd255; b8 = 8'd16; start8 = 1'b1;
    @(negedge clk);
    wait8(lat, bc);
    chk("w8 lat", 64'(lat), 64'd10);
    chk("w8 lo", 64'(lo8), 64'd15);
    chk("w8 hi", 64'(hi8), 64'd15);
    a8 = 8'd200; b8 = 8'd7;
    @(negedge clk);
    chk("w8 idle gap", 64'(busy8), 64'd0);
    @(negedge clk);
    chk("w8 held accept", 64'(busy8), 64'd1);
    start8 = 1'b0;
    wait8(lat, bc);
    chk("w8 2nd lat", 64'(lat), 64'd10);
    chk("w8 2nd lo", 64'(lo8), 64'd28);
    chk("w8 2nd hi", 64'(hi8), 64'd4);

    op8(1'b1, 8'h80, 8'hFF, lat);
    chk("w8 min/-1", {48'd0, lo8, hi8}, {48'd0, 8'h80, 8'h00});
    op8(1'b1, 8'h80, 8'd3, lat);
    chk("w8 -128/3", {48'd0, lo8, hi8}, {48'd0, 8'hD6, 8'hFE});
    op8(1'b1, 8'h05, 8'h00, lat);
    chk("w8 div0", {56'd0, 6'd0, dz8, 1'b0} | 64'(lat), 64'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
